// File: rtl/reg_file_ctrl.sv
// Command sequencer in front of an 8 x 16 register file: one read/write command at a
// time on a valid/ready stream, file strobes from a Moore FSM, response on a second stream.
module reg_file_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wr,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WrData,
    input  logic [DATA_W-1:0] RdData,
    output logic [CNT_W-1:0]  txn_count,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_ISSUE = 3'd1;
    localparam logic [2:0] RD_ISSUE = 3'd2;
    localparam logic [2:0] RD_CAPT  = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    // Both streams: a transfer happens on a rising edge where valid and ready are
    // both high; valid side holds its payload stable until that edge.

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_wr_q, rsp_wr_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0]  txn_count_q, txn_count_d;
    logic              addr_bad;

    assign addr_bad = 32'(cmd_addr) >= DEPTH;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        txn_count_d = txn_count_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    rsp_wr_d    = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    if (addr_bad) begin
                        // Rejected commands go straight to the response, file untouched.
                        state_d   = RESP;
                        rsp_err_d = 1'b1;
                        rsp_wr_d  = cmd_wr;
                    end else if (cmd_wr) begin
                        state_d = WR_ISSUE;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            WR_ISSUE: begin
                state_d  = RESP;
                rsp_wr_d = 1'b1;
            end
            RD_ISSUE: state_d = RD_CAPT;
            RD_CAPT: begin
                state_d     = RESP;
                rsp_rdata_d = RdData;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    txn_count_d = txn_count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            txn_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            txn_count_q <= txn_count_d;
        end
    end

    assign cmd_ready = (state_q == IDLE) && RST;
    assign rsp_valid = (state_q == RESP);
    assign rsp_wr    = rsp_wr_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign WrEn      = (state_q == WR_ISSUE);
    assign RdEn      = (state_q == RD_ISSUE);
    assign Address   = addr_q;
    assign WrData    = wdata_q;
    assign txn_count = txn_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: behavioural register file, command driver, and a monitor
// that pops expected responses (fields plus latency) from a queue.
module tb_reg_file_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_wr;
    logic        rsp_err;
    logic [15:0] rsp_rdata;
    logic        WrEn;
    logic        RdEn;
    logic [7:0]  Address;
    logic [15:0] WrData;
    logic [15:0] RdData = '0;
    logic [15:0] txn_count;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected response: {latency[1:0], wr, err, rdata[15:0]}
    logic [19:0] exp_q[$];

    reg_file_ctrl dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(RdData), .txn_count(txn_count), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    // Register file model: write on WrEn, registered read on RdEn.
    logic [15:0] mem [8];
    logic [7:0]  last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;
    initial for (int i = 0; i < 8; i++) mem[i] = '0;
    always @(posedge CLK) begin
        if (WrEn) begin
            mem[Address[2:0]] <= WrData;
            last_wr_addr <= Address;
            last_wr_data <= WrData;
        end
        if (RdEn) RdData <= mem[Address[2:0]];
    end

    int wr_pulses = 0;
    int rd_pulses = 0;
    int both_hi = 0;
    always @(negedge CLK) begin
        if (WrEn) wr_pulses++;
        if (RdEn) rd_pulses++;
        if (WrEn && RdEn) both_hi++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: latency of first valid, stability under backpressure, fields at handshake.
    int          lat_cnt = 0;
    logic        waiting = 1'b0;
    logic        hold_prev = 1'b0;
    logic [17:0] prev_rsp = '0;
    logic [19:0] e;
    always @(negedge CLK) begin
        if (!RST) begin
            waiting   = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
                check("rsp_held", {14'd0, rsp_wr, rsp_err, rsp_rdata}, {14'd0, prev_rsp});
            end
            if (waiting) lat_cnt++;
            if (rsp_valid && waiting) begin
                waiting = 1'b0;
                if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
                else check("rsp_latency", lat_cnt, {30'd0, exp_q[0][19:18]});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_wr", {31'd0, rsp_wr}, {31'd0, e[17]});
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e[16]});
                    check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e[15:0]});
                end
            end
            hold_prev = rsp_valid && !rsp_ready;
            prev_rsp  = {rsp_wr, rsp_err, rsp_rdata};
            if (cmd_valid && cmd_ready) begin
                waiting = 1'b1;
                lat_cnt = 0;
            end
        end
    end

    // Issue one command, push its expected response, return after the accept edge.
    task automatic send(input logic wr, input logic [7:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rdata);
        logic err;
        logic [1:0] lat;
        int n;
        err = (addr >= 8'd8);
        lat = err ? 2'd1 : (wr ? 2'd2 : 2'd3);
        exp_q.push_back({lat, wr, err, (wr || err) ? 16'h0 : exp_rdata});
        @(posedge CLK); #1;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!cmd_ready && n < 100);
        if (!cmd_ready) check("cmd_accept_timeout", 32'd1, 32'd0);
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) check("rsp_timeout", 32'd1, 32'd0);
    endtask

    int wr0, rd0, n;
    initial begin
        #12;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_outs", {26'd0, rsp_valid, rsp_wr, rsp_err, WrEn, RdEn, 1'b0},
              32'd0);
        check("rst_addr_data_cnt", {Address, WrData ^ txn_count}, 32'd0);
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK);
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // 1: single write
        send(1'b1, 8'd3, 16'hA5A5, 16'h0);
        wait_done();
        check("t1_wr_pulses", wr_pulses, 32'd1);
        check("t1_addr", {24'd0, last_wr_addr}, 32'd3);
        check("t1_data", {16'd0, last_wr_data}, 32'hA5A5);

        // 2: read back
        send(1'b0, 8'd3, 16'h0, 16'hA5A5);
        wait_done();
        check("t2_rd_pulses", rd_pulses, 32'd1);
        check("t2_wr_pulses", wr_pulses, 32'd1);
        check("t2_txn_count", {16'd0, txn_count}, 32'd2);

        // 3: out-of-range addresses
        send(1'b1, 8'd8, 16'h1234, 16'h0);
        wait_done();
        send(1'b0, 8'hFF, 16'h0, 16'h0);
        wait_done();
        check("t3_no_strobes", wr_pulses + rd_pulses, 32'd2);
        check("t3_txn_count", {16'd0, txn_count}, 32'd4);

        // 4: backpressure on a read
        rsp_ready = 1'b0;
        send(1'b0, 8'd3, 16'h0, 16'hA5A5);
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge CLK); n++; end
        check("t4_valid_seen", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("t4_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
            @(negedge CLK);
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        check("t4_idle_state", {29'd0, dbg_state}, 32'd0);
        check("t4_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("t4_txn_count", {16'd0, txn_count}, 32'd5);

        // 5: fill and read back with random gaps
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            send(1'b1, 8'(i), 16'h1000 + 16'(i), 16'h0);
        end
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            send(1'b0, 8'(i), 16'h0, 16'h1000 + 16'(i));
        end
        wait_done();
        check("t5_txn_count", {16'd0, txn_count}, 32'd21);
        check("t5_wr_pulses", wr_pulses, 32'd9);
        check("t5_rd_pulses", rd_pulses, 32'd10);

        // 6: reset during RD_ISSUE
        send(1'b0, 8'd2, 16'h0, 16'h1002);
        n = 0;
        while (!RdEn && n < 20) begin @(negedge CLK); n++; end
        check("t6_rden_seen", {31'd0, RdEn}, 32'd1);
        RST = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rden_drop", {31'd0, RdEn}, 32'd0);
        check("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("t6_txn_count", {16'd0, txn_count}, 32'd0);
        @(negedge CLK); @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        send(1'b1, 8'd5, 16'hBEEF, 16'h0);
        wait_done();
        send(1'b0, 8'd5, 16'h0, 16'hBEEF);
        wait_done();
        check("t6_txn_count_after", {16'd0, txn_count}, 32'd2);

        check("never_both_strobes", both_hi, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
